// File: rtl/clkdiv_sequencer.sv
// Programmable clock divider with a one-deep configuration queue.
// New settings take effect only at a period boundary (falling edge of out_clk).
//
// state | meaning
// IDLE  | divider stopped, out_clk held low, waiting for an enabling config
// RUN   | counting half-periods and toggling out_clk
module clkdiv_sequencer #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic             cfg_en,
   input  logic [CNT_W-1:0] cfg_div,
   output logic             out_clk,
   output logic             tick,
   output logic             running
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] h;
   logic [CNT_W-1:0] cfg_h;
   logic [CNT_W-1:0] pend_h;
   logic             pend_valid;
   logic             pend_en;
   logic             accept;
   logic             term;
   logic             fall;

   // A zero divide request is treated as the fastest setting (divide-by-2).
   assign cfg_h     = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
   assign cfg_ready = ~pend_valid;
   assign accept    = cfg_valid & cfg_ready;
   assign term      = (cnt == h - CNT_W'(1));
   assign fall      = (state == S_RUN) & term & out_clk;
   assign running   = (state == S_RUN);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         h          <= '0;
         out_clk    <= 1'b0;
         tick       <= 1'b0;
         pend_valid <= 1'b0;
         pend_en    <= 1'b0;
         pend_h     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               tick    <= 1'b0;
               cnt     <= '0;
               out_clk <= 1'b0;
               if (accept && cfg_en) begin
                  h     <= cfg_h;
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (term) begin
                  cnt     <= '0;
                  out_clk <= ~out_clk;
                  tick    <= 1'b1;
               end else begin
                  cnt  <= cnt + CNT_W'(1);
                  tick <= 1'b0;
               end
               // Only a config queued before this edge is applied here; a same-edge
               // accept lands in the pending slot and waits a full period.
               if (fall && pend_valid) begin
                  pend_valid <= 1'b0;
                  if (pend_en) h <= pend_h;
                  else         state <= S_IDLE;
               end else if (accept) begin
                  pend_valid <= 1'b1;
                  pend_en    <= cfg_en;
                  pend_h     <= cfg_h;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/clkdiv_sequencer.md
CLKDIV_SEQUENCER -- requirements
Module: clkdiv_sequencer

Interface
REQ-001 The module SHALL have parameter CNT_W, default 8, giving the width of the half-period count.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port cfg_valid, input, 1 bit: a configuration request is presented.
REQ-005 Port cfg_ready, output, 1 bit: the block can accept a configuration.
REQ-006 Port cfg_en, input, 1 bit: 1 = run the divider, 0 = stop it.
REQ-007 Port cfg_div, input, CNT_W bits: requested half-period in clk cycles.
REQ-008 Port out_clk, output, 1 bit: registered divided clock.
REQ-009 Port tick, output, 1 bit: registered pulse in every cycle where out_clk has just changed value.
REQ-010 Port running, output, 1 bit: high while the state is RUN.

Function
REQ-011 A configuration SHALL be accepted on a rising edge where cfg_valid=1 and cfg_ready=1.
REQ-012 The effective half-period h SHALL be cfg_div, except that cfg_div=0 SHALL be treated as h=1.
REQ-013 The block SHALL have two states, IDLE and RUN, plus a single-entry pending register (pend_valid, pend_en, pend_h).
REQ-014 cfg_ready SHALL equal NOT pend_valid in both states.
REQ-015 IDLE, accept with cfg_en=1: load h, clear the counter to 0, go to RUN; out_clk stays 0 on this edge.
REQ-016 IDLE, accept with cfg_en=0: stay in IDLE and change nothing else.
REQ-017 RUN: the counter SHALL increment each cycle; on an edge where the counter equals h-1, the counter SHALL clear to 0, out_clk SHALL toggle and tick SHALL be 1 for the following cycle.
REQ-018 In RUN, tick SHALL be 0 in every other cycle.
REQ-019 Timing: if a run is accepted at edge N, out_clk SHALL rise at edge N+h and fall at edge N+2h, giving a period of 2h cycles and a 50% duty.
REQ-020 With h=1, out_clk SHALL toggle on every edge (divide-by-2).
REQ-021 RUN, accept: the configuration SHALL be stored in the pending register and SHALL NOT affect the current period.
REQ-022 A pending configuration SHALL be applied only on a falling toggle of out_clk (1->0), which is the period boundary; on that edge pend_valid SHALL clear.
REQ-023 Applying pend_en=1: h SHALL become pend_h and the counter SHALL restart at 0, so the next rise comes pend_h cycles later.
REQ-024 Applying pend_en=0: the state SHALL go to IDLE with out_clk=0 (no truncated high pulse); tick SHALL still pulse for that falling toggle.
REQ-025 An accept on the same edge as a falling toggle SHALL be stored as pending and applied at the next falling toggle, not the current one.
REQ-026 In IDLE, out_clk SHALL be 0, tick SHALL be 0 and the counter SHALL hold 0.
REQ-027 The counter SHALL never exceed h-1, so no wrap beyond the CNT_W range can occur.

Reset
REQ-028 rst=1 SHALL immediately and asynchronously force IDLE, counter=0, out_clk=0, tick=0, running=0 and pend_valid=0 (so cfg_ready=1), regardless of clk.
REQ-029 Reset asserted mid-period SHALL discard the current period and any pending configuration; after rst deasserts the block SHALL wait in IDLE for a new accept.

Verification
REQ-030 The bench SHALL check: reset, then accept cfg_en=1, cfg_div=1 at edge N -> out_clk toggles every edge from N+1, tick=1 every cycle, running=1.
REQ-031 The bench SHALL check: accept cfg_div=3 at edge N -> out_clk rises at N+3, falls at N+6, period 6, tick high only in the cycles after N+3, N+6, N+9 and so on.
REQ-032 The bench SHALL check: while running h=3, accept cfg_div=5 mid-high-phase -> cfg_ready=0 until the next falling toggle, then the high and low phases are 5 cycles each.
REQ-033 The bench SHALL check: while running, accept cfg_en=0 -> out_clk completes its current high phase, falls on the boundary, running=0, and out_clk stays 0 afterwards.
REQ-034 The bench SHALL check: cfg_div=0 -> behaves exactly as cfg_div=1.
REQ-035 The bench SHALL check: rst pulsed between clock edges while out_clk=1 with a pending configuration -> out_clk=0 and cfg_ready=1 immediately, and no toggles occur until a new accept.
